// File: rtl/bnn_uart_pkg.sv
// Shared UART definitions for the BNN controller serial link (transmit and receive sides).
package bnn_uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } uart_state_e;

    localparam int unsigned UART_DATA_BITS  = 8;
    localparam logic        UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/bnn_baud_gen.sv
// Bit-period timer: tick pulses on the last cycle of each CLKS_PER_BIT-cycle bit period.
module bnn_baud_gen #(
    parameter int unsigned CLKS_PER_BIT = 87
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] LastCnt = CntW'(CLKS_PER_BIT - 1);

    logic [CntW-1:0] cnt_q;

    assign tick = !clear && (cnt_q == LastCnt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear || tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/bnn_uart_tx.sv
// UART transmitter with byte FIFO and CTS flow control; 8N1, or 8E1 when BNN_UART_PARITY_EN
// is defined.
module bnn_uart_tx
    import bnn_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 87,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    input  logic                          cts_n,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] FullCount = CntW'(FIFO_DEPTH);
    localparam logic [2:0] LastBit = 3'(UART_DATA_BITS - 1);

    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] count_q;
    logic            push, pop;

    logic            cts_meta_q, cts_s_q;
    uart_state_e     state_q, state_d;
    logic [7:0]      data_q;
    logic [2:0]      bit_q, bit_d;
    logic            tx_q, tx_d;
    logic            tick, can_start;

    assign push       = tx_valid && tx_ready;
    assign tx_ready   = (count_q != FullCount);
    assign fifo_count = count_q;
    assign busy       = (state_q != StIdle) || (count_q != '0);
    assign tx         = tx_q;
    assign can_start  = (count_q != '0) && !cts_s_q;

    // Storage needs no reset: occupancy is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= tx_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cts_meta_q <= 1'b1;
            cts_s_q    <= 1'b1;
        end else begin
            cts_meta_q <= cts_n;
            cts_s_q    <= cts_meta_q;
        end
    end

    // Held in clear while idle, so the counter restarts at 0 on every frame start.
    bnn_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_gen (
        .clk  (clk),
        .rst_n(rst_n),
        .clear(state_q == StIdle),
        .tick (tick)
    );

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        case (state_q)
            StIdle: begin
                if (can_start) begin
                    state_d = StStart;
                    pop     = 1'b1;
                    tx_d    = 1'b0;
                end
            end
            StStart: begin
                if (tick) begin
                    state_d = StData;
                    bit_d   = '0;
                    tx_d    = data_q[0];
                end
            end
            StData: begin
                if (tick) begin
                    if (bit_q == LastBit) begin
`ifdef BNN_UART_PARITY_EN
                        state_d = StParity;
                        tx_d    = ^data_q;
`else
                        state_d = StStop;
                        tx_d    = UART_IDLE_LEVEL;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = data_q[bit_d];
                    end
                end
            end
`ifdef BNN_UART_PARITY_EN
            StParity: begin
                if (tick) begin
                    state_d = StStop;
                    tx_d    = UART_IDLE_LEVEL;
                end
            end
`endif
            StStop: begin
                if (tick) begin
                    if (can_start) begin
                        state_d = StStart;
                        pop     = 1'b1;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = StIdle;
                        tx_d    = UART_IDLE_LEVEL;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                tx_d    = UART_IDLE_LEVEL;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            bit_q   <= '0;
            tx_q    <= UART_IDLE_LEVEL;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            if (pop) begin
                data_q <= mem_q[rd_ptr_q];
            end
        end
    end

endmodule

// File: tb/tb_bnn_uart_tx.sv
// Scoreboard bench for bnn_uart_tx: pushed bytes queue up as expectations, a line monitor
// decodes every frame from tx and compares it with the expected bit pattern.
module tb_bnn_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef BNN_UART_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int F = NB * CPB;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       cts_n = 1'b0;
    logic       tx_ready, tx, busy;
    logic [2:0] fifo_count;

    bnn_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .cts_n     (cts_n),
        .tx        (tx),
        .busy      (busy),
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    int         starts[$];
    int         last_accept = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Called at a negedge; returns at the negedge after the accepting posedge.
    task automatic push(input logic [7:0] b);
        int n = 0;
        while (!tx_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!tx_ready) begin
            fail("push_ready_timeout");
        end else begin
            tx_valid = 1'b1;
            tx_data  = b;
            exp_q.push_back(b);
            last_accept = cyc + 1;
            @(negedge clk);
            tx_valid = 1'b0;
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_starts(input int n, input int budget);
        int k = 0;
        while (starts.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (starts.size() < n) fail("frame_start_timeout");
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (busy && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (busy) fail("idle_timeout");
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    // Line monitor: every frame must match start, LSB-first data, [even parity], stop,
    // each bit held for exactly CPB cycles.
    initial begin : monitor
        logic [7:0]  b, got;
        logic [10:0] eb;
        bit          ok, ab;
        forever begin
            @(negedge clk);
            if (rst_n && tx === 1'b0) begin
                starts.push_back(cyc);
                if (exp_q.size() == 0) begin
                    fail("unexpected_frame");
                    b = 8'h00;
                end else begin
                    b = exp_q.pop_front();
                end
`ifdef BNN_UART_PARITY_EN
                eb = {1'b1, ^b, b, 1'b0};
`else
                eb = {2'b11, b, 1'b0};
`endif
                ok  = 1'b1;
                ab  = 1'b0;
                got = 8'h00;
                for (int k = 0; k < NB && !ab; k++) begin
                    for (int c = 0; c < CPB && !ab; c++) begin
                        if (k != 0 || c != 0) @(negedge clk);
                        if (!rst_n) begin
                            ab = 1'b1;
                        end else begin
                            if (tx !== eb[k]) ok = 1'b0;
                            if (c == CPB / 2 && k >= 1 && k <= 8) got[k-1] = tx;
                        end
                    end
                end
                if (!ab) begin
                    check("rx_data", 32'(got), 32'(b));
                    check("frame_shape", 32'(ok), 32'd1);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n0, s, rel;

        repeat (3) @(negedge clk);
        check("reset_tx", 32'(tx), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_ready", 32'(tx_ready), 32'd1);
        check("reset_count", 32'(fifo_count), 32'd0);
        rst_n = 1'b1;
        wait_cycles(3);

        // Single byte: start bit one cycle after accept, busy drops after stop.
        push(8'hA5);
        wait_starts(1, 50);
        if (starts.size() >= 1) begin
            check("start_latency", starts[0], last_accept + 1);
            s = starts[0];
            wait_until(s + F - 1);
            check("busy_in_stop", 32'(busy), 32'd1);
            @(negedge clk);
            check("busy_after_stop", 32'(busy), 32'd0);
            check("tx_idle_high", 32'(tx), 32'd1);
        end

        // CTS held off: FIFO fills, nothing sent; release gives back-to-back frames.
        cts_n = 1'b1;
        wait_cycles(4);
        n0 = starts.size();
        for (int i = 1; i <= 4; i++) push(8'(i));
        check("full_ready", 32'(tx_ready), 32'd0);
        check("full_count", 32'(fifo_count), 32'd4);
        wait_cycles(20);
        check("held_tx", 32'(tx), 32'd1);
        check("held_no_frames", starts.size(), n0);
        cts_n = 1'b0;
        wait_starts(n0 + 4, 4 * F + 50);
        if (starts.size() >= n0 + 4) begin
            for (int i = 1; i < 4; i++) check("b2b_gap", starts[n0+i] - starts[n0+i-1], F);
        end
        wait_idle(100);

        // CTS dropped mid-frame: current frame completes, next waits for CTS.
        cts_n = 1'b1;
        wait_cycles(4);
        n0 = starts.size();
        push(8'h3C);
        push(8'hC3);
        cts_n = 1'b0;
        wait_starts(n0 + 1, 50);
        if (starts.size() >= n0 + 1) begin
            s = starts[n0];
            wait_until(s + CPB * 5);
            cts_n = 1'b1;
            wait_cycles(F + 40);
            check("cts_hold_frames", starts.size(), n0 + 1);
            check("cts_hold_count", 32'(fifo_count), 32'd1);
            check("cts_hold_tx", 32'(tx), 32'd1);
            rel = cyc;
            cts_n = 1'b0;
            wait_starts(n0 + 2, 50);
            if (starts.size() >= n0 + 2) check("cts_resume_latency", starts[n0+1], rel + 3);
        end
        wait_idle(F + 100);

        // Push on the same edge as the STOP->START pop.
        cts_n = 1'b1;
        wait_cycles(4);
        n0 = starts.size();
        push(8'h11);
        push(8'h22);
        push(8'h33);
        cts_n = 1'b0;
        wait_starts(n0 + 1, 50);
        if (starts.size() >= n0 + 1) begin
            s = starts[n0];
            wait_until(s + F - 1);
            check("count_before_pushpop", 32'(fifo_count), 32'd2);
            push(8'h44);
            check("count_after_pushpop", 32'(fifo_count), 32'd2);
        end
        wait_idle(4 * F + 100);
        check("pushpop_drained", exp_q.size(), 0);

        // Reset during data bit 3 with bytes queued.
        cts_n = 1'b1;
        wait_cycles(4);
        n0 = starts.size();
        push(8'h30);
        push(8'h41);
        push(8'h52);
        cts_n = 1'b0;
        wait_starts(n0 + 1, 50);
        if (starts.size() >= n0 + 1) begin
            s = starts[n0];
            wait_until(s + CPB * 4 + 1);
            check("tx_before_reset", 32'(tx), 32'd0);
            #1 rst_n = 1'b0;
            #1;
            check("reset_async_tx", 32'(tx), 32'd1);
            check("reset_mid_count", 32'(fifo_count), 32'd0);
            check("reset_mid_busy", 32'(busy), 32'd0);
            check("reset_mid_ready", 32'(tx_ready), 32'd1);
            wait_cycles(2);
            rst_n = 1'b1;
            exp_q.delete();
            n0 = starts.size();
            wait_cycles(100);
            check("no_frames_after_reset", starts.size(), n0);
            check("tx_after_reset", 32'(tx), 32'd1);
        end

        // Parity-bearing byte, then randomized traffic with random CTS gating.
        push(8'h07);
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(3) == 0) cts_n = ~cts_n;
            if (fifo_count == 3'(DEPTH)) cts_n = 1'b0;
            push(8'($urandom));
            wait_cycles($urandom_range(25));
        end
        cts_n = 1'b0;
        wait_idle(30 * F + 200);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bnn_uart_tx.md
# bnn_uart_tx

Byte-oriented UART transmitter with a small FIFO and CTS flow control that carries classification results and status bytes from the BNN controller back to the host. It pairs with the controller's receive path on the same serial link: the controller pushes bytes through a valid/ready port, and this block serialises them as 8N1 frames, LSB first. It starts a new frame only while the host asserts CTS.

## Interface
- `CLKS_PER_BIT`, 87, clock cycles per serial bit (87 gives 115200 baud at 10 MHz); legal minimum is 4.
- `FIFO_DEPTH`, 4, byte FIFO entries; must be a power of two and at least 2.
- `clk`  in  1  single system clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `tx_data`  in  8  byte to transmit.
- `tx_valid`  in  1  `tx_data` is valid.
- `tx_ready`  out  1  FIFO can accept a byte; high exactly when the FIFO is not full.
- `cts_n`  in  1  host clear-to-send, active-low, asynchronous to `clk`.
- `tx`  out  1  serial line; idles high.
- `busy`  out  1  high when a frame is on the line or the FIFO is non-empty.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  number of bytes currently queued.

## Operation
- Reset values:
  - `tx` = 1, `busy` = 0, `tx_ready` = 1, `fifo_count` = 0.
  - FSM in IDLE; baud and bit counters at 0.
  - `cts_n` synchroniser flops preset to 1 (deasserted).
- Push: a byte is written when `tx_valid && tx_ready` at a rising edge. A push while full cannot occur, because `tx_ready` is low.
- `cts_n` passes through a 2-flop synchroniser (`cts_s`). Only `cts_s` is used.
- FSM states, in order: IDLE, START, DATA, [PARITY], STOP.
- IDLE → START when the FIFO is non-empty and `cts_s` = 0.
  - The head byte is popped into the shift register on that edge.
  - `tx` is registered to 0 on the same edge.
- Each state holds the line for exactly `CLKS_PER_BIT` cycles, timed by the baud counter (0..`CLKS_PER_BIT`-1). The counter clears on every state entry.
- DATA emits bits 0..7, LSB first. A 3-bit index advances on each baud wrap.
- STOP drives `tx` = 1. At the end of STOP:
  - If the FIFO is non-empty and `cts_s` = 0, go directly to START with a new pop. There is zero idle gap between frames.
  - Otherwise go to IDLE.
- CTS is checked only at frame boundaries. Deasserting `cts_n` mid-frame never truncates the current frame.
- Simultaneous push and pop on the same edge: `fifo_count` is unchanged and the data is correct.
  - If the FIFO is empty, the pushed byte is not popped that cycle. The pop needs a non-empty FIFO at the edge.
- Pointers wrap modulo `FIFO_DEPTH`. Full/empty are derived from `fifo_count`.
- Reset asserted mid-frame:
  - `tx` goes high immediately (asynchronous clear).
  - The FIFO is emptied and the frame is abandoned.

## Timing
- `tx` is a registered output. There is no combinational path from any input to `tx`.
- Latency: FIFO empty, FSM in IDLE, `cts_s` already 0, byte accepted at edge N:
  - FSM sees the FIFO non-empty at edge N+1 and `tx` falls after that edge.
  - The frame occupies 10 × `CLKS_PER_BIT` cycles (11 × with parity).
- CTS latency: a `cts_n` change is visible to the FSM 2 edges later.
- `tx_ready` and `fifo_count` update on the edge following a push or pop.
- `busy` is combinational from state and `fifo_count`.

## Configuration
- `BNN_UART_PARITY_EN`
  - Defined: a PARITY state between DATA and STOP emits even parity (XOR of the 8 data bits). The frame is 11 bits.
  - Undefined: PARITY state and logic are absent, and the frame is 8N1 (10 bits).

## Structure
- Package `bnn_uart_pkg` holds:
  - the FSM state enum (IDLE, START, DATA, PARITY, STOP);
  - `UART_DATA_BITS` = 8;
  - `UART_IDLE_LEVEL` = 1'b1.
- The receive side shares this package.
- One sub-module, `bnn_baud_gen`:
  - Parameterised by `CLKS_PER_BIT`.
  - Inputs `clk`, `rst_n`, `clear`; output `tick`, which pulses on the last cycle of each bit period.
- The FIFO stays inline in this block.

## Test plan
- Reset, then push 0xA5 with `cts_n` = 0 and `CLKS_PER_BIT` = 4 → `tx` falls one cycle after accept. Line carries 0,1,0,1,0,0,1,0,1,1, each held 4 cycles, then stays high. `busy` drops after the stop bit.
- `cts_n` = 1, push 4 bytes (0x01–0x04) → `tx_ready` = 0 and `fifo_count` = 4, `tx` stays high. Set `cts_n` = 0 → 4 frames back-to-back with no idle gap, bytes in push order.
- Deassert `cts_n` halfway through the DATA bits of the first of two queued bytes → that frame completes intact, the second does not start until `cts_n` = 0 again.
- Push on the same edge as the STOP→START pop with FIFO at 2 → `fifo_count` stays 2, and all bytes are later transmitted in order.
- Assert `rst_n` = 0 during bit 3 of a frame with 3 bytes queued → `tx` goes to 1 immediately, `fifo_count` = 0, and no further frames appear after release.
- With `BNN_UART_PARITY_EN`, send 0x07 → parity bit = 1 and the frame is 11 bit periods.
